// File: rtl/config_shift_chain_if.sv
// Interface bundle for config_shift_chain: serial load/readback controls and committed outputs.
// Widths follow CFG_PARITY_EN (one extra chain bit when defined).
interface config_shift_chain_if #(
  parameter int NREG  = 4,
  parameter int WIDTH = 8
);
  localparam int TOTAL = NREG * WIDTH;
`ifdef CFG_PARITY_EN
  localparam int LEN = TOTAL + 1;
`else
  localparam int LEN = TOTAL;
`endif
  localparam int BCW = $clog2(LEN + 1) + 1;

  logic             Shift_en;
  logic             Serial_in;
  logic             Load;
  logic             Capture;
  logic [TOTAL-1:0] Default_value;
  logic             Serial_out;
  logic [TOTAL-1:0] Out;
  logic             Busy;
  logic             Load_ok;
  logic             Load_err;
  logic [BCW-1:0]   Bit_count;

  modport master (
    output Shift_en, Serial_in, Load, Capture, Default_value,
    input  Serial_out, Out, Busy, Load_ok, Load_err, Bit_count
  );

  modport slave (
    input  Shift_en, Serial_in, Load, Capture, Default_value,
    output Serial_out, Out, Busy, Load_ok, Load_err, Bit_count
  );
endinterface

// File: rtl/config_shift_chain.sv
// Multi-register configuration shift chain with length-checked commit and serial readback.
// Optional even-parity bit and commit check enabled by macro CFG_PARITY_EN.
module config_shift_chain #(
  parameter int NREG  = 4,
  parameter int WIDTH = 8
) (
  input logic                 Clk,
  input logic                 rst_n,
  config_shift_chain_if.slave bus
);
  localparam int TOTAL = NREG * WIDTH;
`ifdef CFG_PARITY_EN
  localparam int LEN = TOTAL + 1;
`else
  localparam int LEN = TOTAL;
`endif
  localparam int BCW = $clog2(LEN + 1) + 1;
  localparam logic [BCW-1:0] LEN_BC = BCW'(LEN);

  typedef enum logic {IDLE, CHECK} state_t;

  state_t         state;
  logic [LEN-1:0] sr;
  logic [LEN-1:0] cap_val;
  logic           commit_ok;

`ifdef CFG_PARITY_EN
  assign cap_val   = {bus.Out, ^bus.Out};
  assign commit_ok = (bus.Bit_count == LEN_BC) && !(^sr);
`else
  assign cap_val   = bus.Out;
  assign commit_ok = (bus.Bit_count == LEN_BC);
`endif

  assign bus.Serial_out = sr[LEN-1];

  // Default_value is loaded by the asynchronous reset, so it is only observed while rst_n is low.
  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      sr            <= '0;
      bus.Out       <= bus.Default_value;
      bus.Bit_count <= '0;
      bus.Busy      <= 1'b0;
      bus.Load_ok   <= 1'b0;
      bus.Load_err  <= 1'b0;
    end else begin
      bus.Load_ok  <= 1'b0;
      bus.Load_err <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.Load) begin
            state    <= CHECK;
            bus.Busy <= 1'b1;
          end else if (bus.Capture) begin
            sr            <= cap_val;
            bus.Bit_count <= '0;
          end else if (bus.Shift_en) begin
            sr <= {sr[LEN-2:0], bus.Serial_in};
            if (bus.Bit_count != '1)
              bus.Bit_count <= bus.Bit_count + BCW'(1);
          end
        end
        CHECK: begin
          state         <= IDLE;
          bus.Busy      <= 1'b0;
          bus.Bit_count <= '0;
          if (commit_ok) begin
            bus.Out     <= sr[LEN-1 -: TOTAL];
            bus.Load_ok <= 1'b1;
          end else begin
            bus.Load_err <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          bus.Busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_config_shift_chain.sv
// Directed bench for config_shift_chain with NREG=2, WIDTH=4, Default_value=0xA5.
// Parity-specific steps follow CFG_PARITY_EN.
module tb_config_shift_chain;
  localparam int NREG  = 2;
  localparam int WIDTH = 4;
  localparam int TOTAL = NREG * WIDTH;
`ifdef CFG_PARITY_EN
  localparam int LEN = TOTAL + 1;
`else
  localparam int LEN = TOTAL;
`endif

  logic Clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 Clk = ~Clk;

  config_shift_chain_if #(.NREG(NREG), .WIDTH(WIDTH)) bus ();

  config_shift_chain #(.NREG(NREG), .WIDTH(WIDTH)) dut (
    .Clk   (Clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Shift n bits of v, MSB first (bit n-1 first).
  task automatic shift_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      bus.Shift_en  = 1'b1;
      bus.Serial_in = v[i];
      tick();
    end
    bus.Shift_en  = 1'b0;
    bus.Serial_in = 1'b0;
  endtask

  // A full frame: data followed by its parity bit when parity is enabled.
  function automatic logic [31:0] frame(input logic [7:0] d, input logic pbit);
`ifdef CFG_PARITY_EN
    return {23'd0, d, pbit};
`else
    return {24'd0, d} | (32'(pbit) & 32'd0);
`endif
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, "_out"},  32'(bus.Out), 32'hA5);
    check({tag, "_sout"}, 32'(bus.Serial_out), 32'd0);
    check({tag, "_bc"},   32'(bus.Bit_count), 32'd0);
    check({tag, "_busy"}, 32'(bus.Busy), 32'd0);
    check({tag, "_ok"},   32'(bus.Load_ok), 32'd0);
    check({tag, "_err"},  32'(bus.Load_err), 32'd0);
  endtask

  initial begin
    logic [7:0] rb_exp;
    bus.Shift_en      = 1'b0;
    bus.Serial_in     = 1'b0;
    bus.Load          = 1'b0;
    bus.Capture       = 1'b0;
    bus.Default_value = 8'hA5;
    rst_n = 1'b0;
    #12;
    check_reset_state("rst0");
    rst_n = 1'b1;
    tick();

    // Valid commit of 0x3C; a second Load held into CHECK is ignored.
    shift_bits(frame(8'h3C, 1'b0), LEN);
    check("bc_full", 32'(bus.Bit_count), 32'(LEN));
    bus.Load = 1'b1;
    tick();
    check("busy_chk", 32'(bus.Busy), 32'd1);
    check("out_hold", 32'(bus.Out), 32'hA5);
    check("ok_early", 32'(bus.Load_ok), 32'd0);
    tick();
    bus.Load = 1'b0;
    check("out_3c", 32'(bus.Out), 32'h3C);
    check("ok_3c", 32'(bus.Load_ok), 32'd1);
    check("busy_done", 32'(bus.Busy), 32'd0);
    check("bc_clr", 32'(bus.Bit_count), 32'd0);
    tick();
    check("ok_pulse1", 32'(bus.Load_ok), 32'd0);
    check("b2b_err", 32'(bus.Load_err), 32'd0);
    check("b2b_busy", 32'(bus.Busy), 32'd0);

    // Readback of committed 0x3C.
    bus.Capture = 1'b1;
    tick();
    bus.Capture = 1'b0;
    check("cap_bc", 32'(bus.Bit_count), 32'd0);
    rb_exp = 8'h3C;
    for (int i = 7; i >= 0; i--) begin
      check($sformatf("rb_bit%0d", i), 32'(bus.Serial_out), 32'(rb_exp[i]));
      bus.Shift_en = 1'b1;
      tick();
    end
`ifdef CFG_PARITY_EN
    check("rb_par", 32'(bus.Serial_out), 32'd0);
`endif
    bus.Shift_en = 1'b0;

    // Mid-run reset restores defaults.
    rst_n = 1'b0;
    #2;
    check_reset_state("rst1");
    rst_n = 1'b1;
    tick();

    // Short frame of ones; Shift_en held across Load and CHECK must not shift.
    shift_bits(32'hFFFF_FFFF, LEN - 1);
    check("sout_short", 32'(bus.Serial_out), 32'd0);
    bus.Load      = 1'b1;
    bus.Shift_en  = 1'b1;
    bus.Serial_in = 1'b1;
    tick();
    bus.Load = 1'b0;
    check("bc_hold", 32'(bus.Bit_count), 32'(LEN - 1));
    tick();
    check("err_short", 32'(bus.Load_err), 32'd1);
    check("ok_short", 32'(bus.Load_ok), 32'd0);
    check("out_short", 32'(bus.Out), 32'hA5);
    check("sr_hold", 32'(bus.Serial_out), 32'd0);
    bus.Shift_en  = 1'b0;
    bus.Serial_in = 1'b0;
    tick();
    check("err_pulse1", 32'(bus.Load_err), 32'd0);

    // Long frame (LEN+1 bits) is rejected.
    shift_bits(32'h0000_0079, LEN + 1);
    check("bc_long", 32'(bus.Bit_count), 32'(LEN + 1));
    bus.Load = 1'b1;
    tick();
    bus.Load = 1'b0;
    tick();
    check("err_long", 32'(bus.Load_err), 32'd1);
    check("out_long", 32'(bus.Out), 32'hA5);
    tick();

`ifdef CFG_PARITY_EN
    // Parity violation: 0x3D with parity bit 0.
    shift_bits(frame(8'h3D, 1'b0), LEN);
    bus.Load = 1'b1;
    tick();
    bus.Load = 1'b0;
    tick();
    check("err_par", 32'(bus.Load_err), 32'd1);
    check("out_par", 32'(bus.Out), 32'hA5);
    tick();
`endif

    // Reset during CHECK aborts the commit.
    shift_bits(frame(8'h3C, 1'b0), LEN);
    bus.Load = 1'b1;
    tick();
    bus.Load = 1'b0;
    rst_n = 1'b0;
    #2;
    check_reset_state("rst_chk");
    rst_n = 1'b1;
    tick();
    check("rst_chk_ok", 32'(bus.Load_ok), 32'd0);
    check("rst_chk_err", 32'(bus.Load_err), 32'd0);

    // Fresh frame commits normally afterwards.
    shift_bits(frame(8'h5A, 1'b0), LEN);
    bus.Load = 1'b1;
    tick();
    bus.Load = 1'b0;
    tick();
    check("ok_5a", 32'(bus.Load_ok), 32'd1);
    check("out_5a", 32'(bus.Out), 32'h5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end
endmodule

// File: doc/config_shift_chain.md
# config_shift_chain

Parametrised, multi-register successor of the single-register configuration shift register for the MiniMALTA configuration path. A serial chain of `NREG` registers of `WIDTH` bits is shifted in under `Shift_en`. The chain commits to the parallel outputs only when a `Load` request passes a length check, and optionally a parity check. A `Capture` command copies the committed values back into the chain for serial readback.

## Interface
Parameters:
- `NREG`, 4: number of configuration registers in the chain.
- `WIDTH`, 8: bits per register. `TOTAL` = `NREG`*`WIDTH`.
- `LEN` (derived): `TOTAL`, or `TOTAL`+1 with `CFG_PARITY_EN`.

Ports:
- `Clk`, input, 1: clock. All state changes on the rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `Shift_en`, input, 1: shift one bit per cycle while high.
- `Serial_in`, input, 1: serial data, MSB of the frame first.
- `Load`, input, 1: single-cycle commit request.
- `Capture`, input, 1: single-cycle readback request.
- `Default_value`, input, `TOTAL`: committed value applied at reset.
- `Serial_out`, output, 1: `SR[LEN-1]`.
- `Out`, output, `TOTAL`: committed configuration. Register k occupies `Out[k*WIDTH +: WIDTH]`.
- `Busy`, output, 1: high while the FSM is not in IDLE.
- `Load_ok`, output, 1: one-cycle pulse on a successful commit.
- `Load_err`, output, 1: one-cycle pulse on a rejected commit.
- `Bit_count`, output, `$clog2(LEN+1)+1`: bits shifted since the last Load, Capture or reset; saturates at all-ones.

## Operation
- Shift register `SR[LEN-1:0]`. On shift: `SR <= {SR[LEN-2:0], Serial_in}`, and `Bit_count` increments (saturating).
- FSM states:
  - IDLE: accepts Shift, Load and Capture.
  - CHECK: entered for exactly one cycle after `Load`; returns to IDLE unconditionally.
- Priority in IDLE: `Load` > `Capture` > `Shift_en`. Lower-priority inputs in the same cycle are ignored.
- In CHECK, `Shift_en`, `Load` and `Capture` are all ignored; `SR` and `Bit_count` hold.
- Commit is valid iff `Bit_count == LEN` and, with `CFG_PARITY_EN`, the parity rule holds.
  - Valid: `Out <= SR[LEN-1 -: TOTAL]`, pulse `Load_ok`.
  - Invalid: `Out` holds, pulse `Load_err`.
  - Either way `Bit_count` clears to 0 on leaving CHECK.
- Over-shifting (more than `LEN` bits) saturates or exceeds `LEN`, so it is rejected.
- Capture: `SR <= Out` (with parity bit appended when enabled) and `Bit_count <= 0`. The next `LEN` shifts present `Out` MSB first on `Serial_out`.
- Reset values:
  - `SR` = 0, so `Serial_out` = 0.
  - `Out` = `Default_value`.
  - `Bit_count` = 0.
  - FSM = IDLE, `Busy` = 0.
  - `Load_ok` = `Load_err` = 0.
- Reset mid-CHECK aborts the commit and produces no pulse.

## Timing
- Shift: a bit sampled at edge n appears in `SR[0]` after edge n; `Serial_out` changes after edge n.
- `Load` high at edge n:
  - `Busy` is high during cycle n..n+1.
  - At edge n+1, `Out` updates and the `Load_ok`/`Load_err` registers set.
  - Pulses are high for exactly one cycle, n+1..n+2.
  - `Busy` is low again after edge n+1.
- Back-to-back: `Load` at edge n+1 is ignored because `Busy` is still high. The earliest accepted `Load` is at edge n+2.
- Capture at edge n: `SR` is valid after edge n and `Serial_out` = `Out[TOTAL-1]` immediately.
- `Default_value` is sampled only while reset is asserted.

## Configuration
- Macro `CFG_PARITY_EN`.
- Defined:
  - `LEN` = `TOTAL`+1; the last bit shifted (`SR[0]`) is an even-parity bit.
  - Commit additionally requires `^SR == 0`.
  - Capture loads `{Out, ^Out}`.
- Undefined:
  - `LEN` = `TOTAL`, with no parity bit or check.
  - Capture loads `Out`.

## Test plan
All scenarios use `NREG`=2, `WIDTH`=4, `Default_value`=0xA5.
- Reset: assert `rst_n`=0 mid-run -> `Out`=0xA5, `Serial_out`=0, `Bit_count`=0, `Busy`=0, no pulses.
- No parity: shift 0x3C (8 bits, MSB first), then `Load` -> `Out`=0x3C one edge after `Load`, `Load_ok` high for one cycle, `Bit_count`=0.
- Wrong length: shift 7 or 9 bits, then `Load` -> `Load_err` for one cycle, `Out` stays 0xA5; `Shift_en` held during CHECK does not change `SR`.
- Readback: after committing 0x3C, `Capture`, then shift 8 bits -> `Serial_out` sequence 0,0,1,1,1,1,0,0.
- `CFG_PARITY_EN`:
  - 0x3C followed by parity bit 0 -> `Load_ok`, `Out`=0x3C.
  - 0x3D followed by parity bit 0 -> `Load_err`, `Out` unchanged.
- `rst_n` low during CHECK -> `Out`=0xA5, no `Load_ok` or `Load_err`; a new 8-bit frame then commits normally.
